div_tick_ctrl: RTL and testbench



---
 rtl/div_tick_ctrl.sv | 118 +++++++++++
 tb/tb_div_tick_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_tick_ctrl.sv
// rtl/div_tick_ctrl.sv - multi-channel programmable tick (clock-enable) scheduler
// Optional TICK_CLKOUT_EN adds a per-channel square-wave clk_out toggled by each tick.
module div_tick_ctrl #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int CW = 2
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_div,
    input  logic          cfg_run,
    output logic          cfg_err,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] running
`ifdef TICK_CLKOUT_EN
    ,
    output logic [CH-1:0] clk_out
`endif
);

    typedef enum logic {IDLE, APPLY} state_t;

    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

    state_t        state_q, state_d;
    logic [CW-1:0] ch_q;
    logic [W-1:0]  div_hold_q;
    logic          run_hold_q;
    logic          cfg_err_q;
    logic          accept, apply, req_ok;

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_d = APPLY;
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = cfg_valid && (state_q == IDLE);
    assign apply  = (state_q == APPLY);
    // A zero divisor is only meaningful for a stop request.
    assign req_ok = ({1'b0, ch_q} < CH_LIM) && !(run_hold_q && (div_hold_q == '0));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            div_hold_q <= '0;
            run_hold_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= apply && !req_ok;
            if (accept) begin
                ch_q       <= cfg_ch;
                div_hold_q <= cfg_div;
                run_hold_q <= cfg_run;
            end
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] div_q, cnt_q;
        logic         tick_q, run_q, sel;

        assign sel = apply && req_ok && (ch_q == CW'(i));

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                div_q  <= '0;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                run_q  <= 1'b0;
            end else if (sel) begin
                div_q  <= div_hold_q;
                run_q  <= run_hold_q;
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (run_q) begin
                if (cnt_q == div_q - W'(1)) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + W'(1);
                    tick_q <= 1'b0;
                end
            end else begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end
        end

        assign tick[i]    = tick_q;
        assign running[i] = run_q;

`ifdef TICK_CLKOUT_EN
        logic clk_q;
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset)       clk_q <= 1'b0;
            else if (sel)    clk_q <= 1'b0;
            else if (tick_q) clk_q <= ~clk_q;
        end
        assign clk_out[i] = clk_q;
`endif
    end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// tb/tb_div_tick_ctrl.sv - scoreboard bench for div_tick_ctrl against a period/phase model
module tb_div_tick_ctrl;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch  = '0;
    logic [W-1:0]  cfg_div = '0;
    logic          cfg_run = 1'b0;
    logic          cfg_err;
    logic [CH-1:0] tick, running;
`ifdef TICK_CLKOUT_EN
    logic [CH-1:0] clk_out;
`endif

    div_tick_ctrl #(.CH(CH), .W(W), .CW(CW)) dut (
        .clk_in(clk_in), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_run(cfg_run),
        .cfg_err(cfg_err), .tick(tick), .running(running)
`ifdef TICK_CLKOUT_EN
        , .clk_out(clk_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int a;
        int ch;
        int d;
        bit run;
        bit err;
    } req_t;

    req_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_a [CH];
    int   m_d [CH];
    bit   m_run [CH];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Expected outputs follow directly from phase: ticks land D, 2D, 3D... cycles after apply.
    always @(negedge clk_in) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < CH; i++) m_run[i] = 1'b0;
            check("reset_outputs", {cfg_ready, cfg_err, tick, running}, {1'b1, 1'b0, {CH{1'b0}}, {CH{1'b0}}});
        end else begin
            logic [CH-1:0] et, er, ec;
            bit popped;
            req_t r;
            popped = 1'b0;
            if (q.size() > 0 && q[0].a == cyc) begin
                r = q.pop_front();
                popped = 1'b1;
                if (!r.err) begin
                    m_a[r.ch]   = cyc;
                    m_d[r.ch]   = r.d;
                    m_run[r.ch] = r.run;
                end
            end
            check("cfg_err", cfg_err, popped && r.err);
            check("cfg_ready", cfg_ready, !(q.size() > 0 && q[0].a == cyc + 1));
            et = '0; er = '0; ec = '0;
            for (int i = 0; i < CH; i++) begin
                er[i] = m_run[i];
                if (m_run[i] && cyc > m_a[i]) begin
                    et[i] = ((cyc - m_a[i]) % m_d[i]) == 0;
                    ec[i] = (((cyc - m_a[i] - 1) / m_d[i]) % 2) == 1;
                end
            end
            check("tick", tick, et);
            check("running", running, er);
`ifdef TICK_CLKOUT_EN
            check("clk_out", clk_out, ec);
`endif
        end
    end

    task automatic send(input int ch, input int d, input bit run);
        int n;
        req_t r;
        @(negedge clk_in);
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_div   = W'(d);
        cfg_run   = run;
        n = 0;
        while (!cfg_ready && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        if (!cfg_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            r.a   = cyc + 2;
            r.ch  = ch;
            r.d   = d;
            r.run = run;
            r.err = (ch >= CH) || (run && d == 0);
            q.push_back(r);
        end
        @(posedge clk_in);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            m_a[i] = 0; m_d[i] = 1; m_run[i] = 1'b0;
        end
        idle(3);
        reset = 1'b0;
        idle(20);

        send(0, 4, 1);
        idle(44);

        send(1, 1, 1);
        send(2, 3, 1);
        idle(20);

        // Land the reconfigure apply edge on ch0 cnt==2.
        for (int n = 0; n < 8 && ((cyc - m_a[0]) % 4) != 1; n++) @(negedge clk_in);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd6; cfg_run = 1'b1;
        begin
            req_t r;
            r.a = cyc + 2; r.ch = 0; r.d = 6; r.run = 1'b1; r.err = 1'b0;
            q.push_back(r);
        end
        @(posedge clk_in);
        #1 cfg_valid = 1'b0;
        idle(20);

        send(5, 7, 1);
        send(3, 0, 1);
        send(1, 9, 0);
        idle(20);

        for (int k = 0; k < 30; k++) begin
            send($urandom_range(0, 5), $urandom_range(0, 9), 1'($urandom_range(0, 3) != 0));
            idle($urandom_range(0, 12));
        end
        idle(20);

        send(3, 255, 1);
        idle(520);

        send(2, 3, 1);
        idle(6);
        send(2, 3, 1);
        reset = 1'b1;
        #1;
        check("reset_in_apply", {cfg_ready, cfg_err, tick, running}, {1'b1, 1'b0, {CH{1'b0}}, {CH{1'b0}}});
`ifdef TICK_CLKOUT_EN
        check("reset_clk_out", clk_out, 0);
`endif
        idle(3);
        reset = 1'b0;
        idle(30);

        send(0, 4, 1);
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
